ram_connector: RTL and testbench

RAM_CONNECTOR -- requirements
Module: ram_connector

---
 rtl/conv_pkg.sv | 19 +
 rtl/conv_line_ram.sv | 18 +
 rtl/ram_connector.sv | 76 +++++++
 tb/tb_ram_connector.sv | 110 +++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared pixel type, image/kernel geometry and fixed Q6.10 kernel for ram_connector
package conv_pkg;
  typedef logic signed [15:0] pixel_t;
  localparam int IMG_W = 10;
  localparam int IMG_H = 10;
  localparam int K = 3;
  localparam int STRIDE = 2;
  localparam int FRAC = 10;
  localparam int OUT_N = 16;
  localparam int ACW = 40;
  localparam pixel_t CONV_W [3][3] = '{'{16'sd1024, 16'sd1024, 16'sd1024},
                                       '{16'sd1024, 16'sd1024, 16'sd1024},
                                       '{16'sd1024, 16'sd1024, 16'sd1024}};
  localparam pixel_t CONV_B = 16'sd0;
  // Negatives collapse to zero, so only the positive rail needs clamping.
  function automatic pixel_t sat_relu(input logic signed [ACW-1:0] v);
    return v < 0 ? '0 : (v > 32767 ? 16'sd32767 : v[15:0]);
  endfunction
endpackage

// File: rtl/conv_line_ram.sv
// conv_line_ram: previous-rows buffer, one word per column holding all buffered rows
module conv_line_ram #(
  parameter int ROWS = 2,
  parameter int DEPTH = 10,
  parameter int AW = 4
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [AW-1:0]        raddr,
  input  logic [16*ROWS-1:0]   wdata,
  output logic [16*ROWS-1:0]   rdata
);
  logic [16*ROWS-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/ram_connector.sv
// ram_connector: streaming strided KxK convolution with ReLU over one raster frame per reset
module ram_connector #(
  parameter int IMG_W = conv_pkg::IMG_W,
  parameter int IMG_H = conv_pkg::IMG_H,
  parameter int K = conv_pkg::K,
  parameter int STRIDE = conv_pkg::STRIDE,
  parameter int FRAC = conv_pkg::FRAC
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [15:0] inputPixel,
  output logic signed [15:0] overallOut [conv_pkg::OUT_N-1:0]
);
  import conv_pkg::*;
  localparam int OUT_H = (IMG_H - K) / STRIDE + 1;
  localparam int OUT_W = (IMG_W - K) / STRIDE + 1;
  localparam int CW = $clog2(IMG_W > IMG_H ? IMG_W : IMG_H);
  localparam int OW = $clog2(OUT_N);
  logic [CW-1:0] row, col;
  logic done, fire, hit, last_col, last_row;
  logic [OW-1:0] fire_idx, hit_idx;
  logic [16*(K-1)-1:0] rd, wd;
  logic signed [ACW-1:0] acc;
  pixel_t win [K][K];
  pixel_t col_v [K];
  int ri, ci;
  conv_line_ram #(.ROWS(K-1), .DEPTH(IMG_W), .AW(CW)) u_ram (
    .clk(clk), .we(!done), .waddr(col), .raddr(col), .wdata(wd), .rdata(rd)
  );
  // Each RAM word ages by one row per write: oldest row in the low slot.
  always_comb begin
    col_v[K-1] = inputPixel;
    wd = '0;
    for (int i = 0; i < K-1; i++) col_v[i] = rd[16*i +: 16];
    for (int i = 0; i < K-1; i++) wd[16*i +: 16] = col_v[i+1];
  end
  always_comb begin
    ri = int'(row);
    ci = int'(col);
    last_col = col == CW'(IMG_W - 1);
    last_row = row == CW'(IMG_H - 1);
    hit = !done && ri >= K-1 && ci >= K-1 && (ri-(K-1)) % STRIDE == 0 && (ci-(K-1)) % STRIDE == 0
          && (ri-(K-1)) / STRIDE < OUT_H && (ci-(K-1)) / STRIDE < OUT_W;
    hit_idx = OW'(((ri-(K-1)) / STRIDE) * OUT_W + (ci-(K-1)) / STRIDE);
  end
  always_comb begin
    acc = ACW'(CONV_B) <<< FRAC;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        acc = acc + ACW'(win[i][j]) * ACW'(CONV_W[i][j]);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      row <= '0;
      col <= '0;
      done <= 1'b0;
      fire <= 1'b0;
      fire_idx <= '0;
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++) win[i][j] <= '0;
      for (int i = 0; i < OUT_N; i++) overallOut[i] <= '0;
    end else begin
      fire <= hit;
      fire_idx <= hit_idx;
      if (!done) begin
        col <= last_col ? '0 : col + 1'b1;
        row <= last_col ? row + 1'b1 : row;
        done <= last_col && last_row;
        for (int i = 0; i < K; i++) begin
          for (int j = 0; j < K-1; j++) win[i][j] <= win[i][j+1];
          win[i][K-1] <= col_v[i];
        end
      end
      if (fire) overallOut[fire_idx] <= sat_relu(acc >>> FRAC);
    end
endmodule

// File: tb/tb_ram_connector.sv
// tb_ram_connector: directed frames with a scoreboard of window results for ram_connector
module tb_ram_connector;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic signed [15:0] inputPixel = '0;
  logic signed [15:0] overallOut [15:0];
  typedef struct {int idx; int val; int due;} exp_t;
  exp_t q[$];
  int tests = 0, fails = 0, cyc = 0, n = 0;
  int img [10][10];
  int exp_out [16];

  always #5 clk = ~clk;

  ram_connector dut (.clk(clk), .reset(reset), .inputPixel(inputPixel), .overallOut(overallOut));

  task automatic chk(input string tag, input int got, input int want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic chk_all(input string tag, input int want);
    for (int i = 0; i < 16; i++) chk($sformatf("%s[%0d]", tag, i), int'(overallOut[i]), want);
  endtask

  // Drive one pixel, check results falling due, and predict any window it completes.
  task automatic step(input int v);
    int r, c, s, idx;
    inputPixel = 16'(v);
    @(posedge clk);
    #1;
    cyc++;
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      chk($sformatf("out[%0d]", e.idx), int'(overallOut[e.idx]), e.val);
      exp_out[e.idx] = e.val;
    end
    if (n < 100) begin
      r = n / 10;
      c = n % 10;
      img[r][c] = int'(inputPixel);
      if (r >= 2 && c >= 2 && r % 2 == 0 && c % 2 == 0) begin
        s = 0;
        for (int i = r - 2; i <= r; i++)
          for (int j = c - 2; j <= c; j++) s += img[i][j];
        s = s < 0 ? 0 : (s > 32767 ? 32767 : s);
        idx = ((r - 2) / 2) * 4 + (c - 2) / 2;
        chk($sformatf("early[%0d]", idx), int'(overallOut[idx]), 0);
        q.push_back('{idx, s, cyc + 1});
      end
      n++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk_all("rst", 0);
    q.delete();
    n = 0;
    for (int i = 0; i < 16; i++) exp_out[i] = 0;
    @(posedge clk);
    #1;
    chk("rst_hold0", int'(overallOut[0]), 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic ramp_checks();
    chk("ramp0", int'(overallOut[0]), 99);
    chk("ramp1", int'(overallOut[1]), 117);
    chk("ramp4", int'(overallOut[4]), 279);
    chk("ramp15", int'(overallOut[15]), 693);
  endtask

  initial begin
    #2;
    chk_all("por", 0);
    do_reset();
    for (int p = 0; p < 100; p++) step(p);
    step(0);
    ramp_checks();
    for (int p = 0; p < 10; p++) step(int'($urandom_range(0, 60000)) - 30000);
    for (int i = 0; i < 16; i++) chk($sformatf("hold[%0d]", i), int'(overallOut[i]), exp_out[i]);
    do_reset();
    for (int p = 0; p < 110; p++) step(1);
    chk_all("ones", 9);
    do_reset();
    for (int p = 0; p < 101; p++) step(-5);
    chk_all("neg", 0);
    do_reset();
    for (int p = 0; p < 101; p++) step(32767);
    chk_all("sat", 32767);
    do_reset();
    for (int p = 0; p < 50; p++) step(p);
    #2;
    do_reset();
    for (int p = 0; p < 101; p++) step(p);
    ramp_checks();
    do_reset();
    for (int p = 0; p < 101; p++) step(int'($urandom_range(0, 8000)) - 4000);
    for (int i = 0; i < 16; i++) chk($sformatf("rnd[%0d]", i), int'(overallOut[i]), exp_out[i]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
